// File: rtl/clock_time_setter.sv
// Push-button time/date editor: debounces mode/next/inc, edits BCD shadow copies of the
// live clock and calendar, and loads them back into the counters with a one-cycle strobe.
module clock_time_setter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_DIV       = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  input  logic [7:0] cur_year,
  input  logic [7:0] cur_mon,
  input  logic [7:0] cur_day,
  output logic [7:0] set_hour,
  output logic [7:0] set_min,
  output logic [7:0] set_sec,
  output logic [7:0] set_year,
  output logic [7:0] set_mon,
  output logic [7:0] set_day,
  output logic       load_time,
  output logic       load_date,
  output logic       editing,
  output logic [2:0] field_sel,
  output logic       blink
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int BL_W = $clog2(BLINK_DIV) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    E_HOUR = 3'd1,
    E_MIN  = 3'd2,
    E_SEC  = 3'd3,
    E_YEAR = 3'd4,
    E_MON  = 3'd5,
    E_DAY  = 3'd6,
    COMMIT = 3'd7
  } state_t;

  // BCD +1 with wrap once the value reaches its top
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top,
                                         input logic [7:0] wrap);
    logic [7:0] r;
    if (v >= top) r = wrap;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else r = v + 8'd1;
    return r;
  endfunction

  // Binary year mod 4 equals (2*tens + ones) mod 4, so only a few BCD bits matter
  function automatic logic [7:0] max_day(input logic [7:0] year, input logic [7:0] mon);
    logic [1:0] yr_mod4;
    logic [7:0] r;
    yr_mod4 = {year[4], 1'b0} + year[1:0];
    case (mon)
      8'h02:                      r = (yr_mod4 == 2'd0) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
      default:                    r = 8'h31;
    endcase
    return r;
  endfunction

  logic [2:0]      btn_raw_s, sync1_r, sync2_r, db_r, db_d_r, pulse_s;
  logic [DB_W-1:0] db_cnt_r [3];
  logic            mode_s, next_s, inc_s;

  state_t          state_r, state_nxt_s;
  logic [2:0]      field_sel_r, field_sel_nxt_s;
  logic            editing_r, editing_nxt_s, load_r, load_nxt_s;
  logic [BL_W-1:0] blink_cnt_r;
  logic            blink_r;

  logic [7:0]      hour_r, min_r, sec_r, year_r, mon_r, day_r, max_day_s;
  logic            clamp_pend_r;

  assign btn_raw_s = {btn_inc, btn_next, btn_mode};

  // Synchronize each button, then accept a level only after it has held still long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      db_r    <= 3'b000;
      db_d_r  <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt_r[i] <= '0;
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
      db_d_r  <= db_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_r[i]     <= sync2_r[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
        end
      end
    end
  end

  assign pulse_s = db_r & ~db_d_r;
  assign mode_s  = pulse_s[0];
  assign next_s  = pulse_s[1] & ~pulse_s[0];
  assign inc_s   = pulse_s[2] & ~pulse_s[1] & ~pulse_s[0];

  // State register plus registered copies of the state-decoded outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      field_sel_r <= 3'd0;
      editing_r   <= 1'b0;
      load_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      field_sel_r <= field_sel_nxt_s;
      editing_r   <= editing_nxt_s;
      load_r      <= load_nxt_s;
    end
  end

  // Next-state logic; mode outranks next, which outranks inc
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN:    if (mode_s) state_nxt_s = E_HOUR; else state_nxt_s = RUN;
      E_HOUR, E_MIN, E_SEC, E_YEAR, E_MON: begin
        if (mode_s) state_nxt_s = COMMIT;
        else if (next_s) state_nxt_s = state_t'(state_r + 3'd1);
        else state_nxt_s = state_r;
      end
      E_DAY: begin
        if (mode_s) state_nxt_s = COMMIT;
        else if (next_s) state_nxt_s = E_HOUR;
        else state_nxt_s = E_DAY;
      end
      COMMIT: state_nxt_s = RUN;
      default: state_nxt_s = RUN;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with state_r
  always_comb begin
    field_sel_nxt_s = 3'd0;
    case (state_nxt_s)
      E_HOUR:  field_sel_nxt_s = 3'd1;
      E_MIN:   field_sel_nxt_s = 3'd2;
      E_SEC:   field_sel_nxt_s = 3'd3;
      E_YEAR:  field_sel_nxt_s = 3'd4;
      E_MON:   field_sel_nxt_s = 3'd5;
      E_DAY:   field_sel_nxt_s = 3'd6;
      default: field_sel_nxt_s = 3'd0;
    endcase
    editing_nxt_s = (field_sel_nxt_s != 3'd0);
    load_nxt_s    = (state_nxt_s == COMMIT);
  end

  // Blink phase restarts only when editing begins; field changes keep the running phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r <= '0;
      blink_r     <= 1'b0;
    end else if (!editing_nxt_s || !editing_r) begin
      blink_cnt_r <= '0;
      blink_r     <= 1'b0;
    end else if (blink_cnt_r == BL_LAST) begin
      blink_cnt_r <= '0;
      blink_r     <= ~blink_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BL_W'(1);
    end
  end

  assign max_day_s = max_day(year_r, mon_r);

  // Shadow registers: snapshot on edit entry, BCD increments, day clamp one cycle after mon/year move
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_r       <= 8'h00;
      min_r        <= 8'h00;
      sec_r        <= 8'h00;
      year_r       <= 8'h00;
      mon_r        <= 8'h01;
      day_r        <= 8'h01;
      clamp_pend_r <= 1'b0;
    end else begin
      clamp_pend_r <= 1'b0;
      if (clamp_pend_r && (day_r > max_day_s)) day_r <= max_day_s;
      if ((state_r == RUN) && mode_s) begin
        hour_r <= cur_hour;
        min_r  <= cur_min;
        sec_r  <= cur_sec;
        year_r <= cur_year;
        mon_r  <= cur_mon;
        day_r  <= cur_day;
      end else if (inc_s) begin
        case (state_r)
          E_HOUR: hour_r <= bcd_inc(hour_r, 8'h23, 8'h00);
          E_MIN:  min_r  <= bcd_inc(min_r, 8'h59, 8'h00);
          E_SEC:  sec_r  <= bcd_inc(sec_r, 8'h59, 8'h00);
          E_YEAR: begin
            year_r       <= bcd_inc(year_r, 8'h99, 8'h00);
            clamp_pend_r <= 1'b1;
          end
          E_MON: begin
            mon_r        <= bcd_inc(mon_r, 8'h12, 8'h01);
            clamp_pend_r <= 1'b1;
          end
          E_DAY:  day_r  <= bcd_inc(day_r, max_day_s, 8'h01);
          default: hour_r <= hour_r;
        endcase
      end else begin
        hour_r <= hour_r;
      end
    end
  end

  assign set_hour  = hour_r;
  assign set_min   = min_r;
  assign set_sec   = sec_r;
  assign set_year  = year_r;
  assign set_mon   = mon_r;
  assign set_day   = day_r;
  assign load_time = load_r;
  assign load_date = load_r;
  assign editing   = editing_r;
  assign field_sel = field_sel_r;
  assign blink     = blink_r;

endmodule

// File: tb/tb_clock_time_setter.sv
// Bench for clock_time_setter: integer-valued calendar model checked every cycle,
// plus directed button sequences with hand-computed literal expectations.
module tb_clock_time_setter;
  localparam int D  = 4;
  localparam int BD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0;
  logic [7:0] cur_hour, cur_min, cur_sec, cur_year, cur_mon, cur_day;
  logic [7:0] set_hour, set_min, set_sec, set_year, set_mon, set_day;
  logic load_time, load_date, editing, blink;
  logic [2:0] field_sel;

  always #5 clk = ~clk;

  clock_time_setter #(.DEBOUNCE_CYCLES(D), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .cur_year(cur_year), .cur_mon(cur_mon), .cur_day(cur_day),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_year(set_year), .set_mon(set_mon), .set_day(set_day),
    .load_time(load_time), .load_date(load_date), .editing(editing),
    .field_sel(field_sel), .blink(blink));

  int n_assert = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: state 0 = running, 1..6 = editing that field, 7 = commit cycle
  int m_state, m_hour, m_min, m_sec, m_year, m_mon, m_day, m_ecount;
  bit m_clamp;
  bit m_db [3];
  bit m_pend [3];
  bit m_hist [3][D+2];

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t, o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int mdays(input int y, input int m);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic model_reset();
    m_state = 0; m_hour = 0; m_min = 0; m_sec = 0; m_year = 0; m_mon = 1; m_day = 1;
    m_ecount = 0; m_clamp = 1'b0;
    for (int b = 0; b < 3; b++) begin
      m_db[b] = 1'b0; m_pend[b] = 1'b0;
      for (int j = 0; j < D + 2; j++) m_hist[b][j] = 1'b0;
    end
  endtask

  task automatic model_step();
    int old, day_n;
    bit pm, pn, pi, all_diff, newdb;
    bit raw [3];
    if (!rst_n) begin
      model_reset();
      return;
    end
    raw[0] = btn_mode; raw[1] = btn_next; raw[2] = btn_inc;
    old = m_state;
    pm = m_pend[0];
    pn = m_pend[1] && !pm;
    pi = m_pend[2] && !pm && !m_pend[1];
    day_n = m_day;
    if (m_clamp && m_day > mdays(m_year, m_mon)) day_n = mdays(m_year, m_mon);
    m_clamp = 1'b0;
    if (old == 7) m_state = 0;
    else if (old == 0) begin
      if (pm) begin
        m_state = 1;
        m_hour = from_bcd(cur_hour); m_min = from_bcd(cur_min); m_sec = from_bcd(cur_sec);
        m_year = from_bcd(cur_year); m_mon = from_bcd(cur_mon); day_n = from_bcd(cur_day);
      end
    end else if (pm) m_state = 7;
    else if (pn) m_state = old % 6 + 1;
    else if (pi) begin
      case (old)
        1: m_hour = (m_hour + 1) % 24;
        2: m_min = (m_min + 1) % 60;
        3: m_sec = (m_sec + 1) % 60;
        4: begin m_year = (m_year + 1) % 100; m_clamp = 1'b1; end
        5: begin m_mon = m_mon % 12 + 1; m_clamp = 1'b1; end
        default: day_n = (m_day >= mdays(m_year, m_mon)) ? 1 : m_day + 1;
      endcase
    end
    m_day = day_n;
    if (m_state >= 1 && m_state <= 6) m_ecount = (old >= 1 && old <= 6) ? m_ecount + 1 : 0;
    else m_ecount = 0;
    // A button level is accepted once its last D synchronized samples all disagree with it
    for (int b = 0; b < 3; b++) begin
      for (int j = D + 1; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
      m_hist[b][0] = raw[b];
      all_diff = 1'b1;
      for (int j = 2; j <= D + 1; j++) if (m_hist[b][j] == m_db[b]) all_diff = 1'b0;
      newdb = all_diff ? !m_db[b] : m_db[b];
      m_pend[b] = newdb && !m_db[b];
      m_db[b] = newdb;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT and the model's own value against a hand-computed literal
  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] mval,
                     input logic [7:0] exp);
    chk(name, act, exp);
    chk({"model_", name}, mval, exp);
  endtask

  function automatic logic [7:0] m_fsel();
    return (m_state >= 1 && m_state <= 6) ? 8'(m_state) : 8'd0;
  endfunction

  function automatic logic m_blink();
    return (m_state >= 1 && m_state <= 6) && ((m_ecount / BD) % 2 == 1);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("set_hour", set_hour, to_bcd(m_hour));
        chk("set_min", set_min, to_bcd(m_min));
        chk("set_sec", set_sec, to_bcd(m_sec));
        chk("set_year", set_year, to_bcd(m_year));
        chk("set_mon", set_mon, to_bcd(m_mon));
        chk("set_day", set_day, to_bcd(m_day));
        chk("field_sel", {5'd0, field_sel}, m_fsel());
        chk("editing", {7'd0, editing}, {7'd0, m_fsel() != 8'd0});
        chk("load_time", {7'd0, load_time}, {7'd0, m_state == 7});
        chk("load_date", {7'd0, load_date}, {7'd0, m_state == 7});
        chk("blink", {7'd0, blink}, {7'd0, m_blink()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic press(input logic [2:0] m, input int hold);
    {btn_inc, btn_next, btn_mode} = m;
    repeat (hold) tick();
    {btn_inc, btn_next, btn_mode} = 3'b000;
    repeat (10) tick();
  endtask

  task automatic press_n(input logic [2:0] m, input int n);
    for (int i = 0; i < n; i++) press(m, 8);
  endtask

  localparam logic [2:0] MODE = 3'b001;
  localparam logic [2:0] NEXT = 3'b010;
  localparam logic [2:0] INC  = 3'b100;

  initial begin
    bit found;
    cur_hour = 8'h23; cur_min = 8'h59; cur_sec = 8'h58;
    cur_year = 8'h99; cur_mon = 8'h12; cur_day = 8'h31;
    model_reset();
    chk_en = 1'b1;
    repeat (3) tick();
    lit("rst_mon", set_mon, to_bcd(m_mon), 8'h01);
    lit("rst_day", set_day, to_bcd(m_day), 8'h01);
    lit("rst_hour", set_hour, to_bcd(m_hour), 8'h00);
    lit("rst_fsel", {5'd0, field_sel}, m_fsel(), 8'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Enter edit with the live values snapshotted
    press(MODE, 10);
    lit("entry_editing", {7'd0, editing}, m_fsel() != 8'd0 ? 8'd1 : 8'd0, 8'd1);
    lit("entry_fsel", {5'd0, field_sel}, m_fsel(), 8'd1);
    lit("entry_hour", set_hour, to_bcd(m_hour), 8'h23);
    lit("entry_min", set_min, to_bcd(m_min), 8'h59);
    lit("entry_day", set_day, to_bcd(m_day), 8'h31);
    lit("entry_load", {7'd0, load_time}, {7'd0, m_state == 7}, 8'd0);

    press(INC, 8);
    lit("hour_wrap", set_hour, to_bcd(m_hour), 8'h00);
    press(NEXT, 8);
    press_n(INC, 6);
    lit("min_05", set_min, to_bcd(m_min), 8'h05);
    press_n(INC, 10);
    lit("min_15", set_min, to_bcd(m_min), 8'h15);

    // Date edits: year 01, mon 01, then mon 02 forces day 31 down to 28
    press_n(NEXT, 2);
    press_n(INC, 2);
    lit("year_01", set_year, to_bcd(m_year), 8'h01);
    press(NEXT, 8);
    press(INC, 8);
    lit("mon_01", set_mon, to_bcd(m_mon), 8'h01);
    press(INC, 8);
    lit("mon_02", set_mon, to_bcd(m_mon), 8'h02);
    lit("clamp_28", set_day, to_bcd(m_day), 8'h28);
    press_n(NEXT, 5);
    press_n(INC, 3);
    lit("year_04", set_year, to_bcd(m_year), 8'h04);
    press_n(NEXT, 2);
    press(INC, 8);
    lit("leap_29", set_day, to_bcd(m_day), 8'h29);
    press_n(NEXT, 4);
    press(INC, 8);
    lit("year_05", set_year, to_bcd(m_year), 8'h05);
    lit("clamp_28b", set_day, to_bcd(m_day), 8'h28);

    // Commit: find the strobe cycle within a bounded window
    btn_mode = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (load_time === 1'b1) found = 1'b1;
    end
    n_assert++;
    if (!found) begin
      n_fail++;
      $display("FAIL commit_strobe: got no load_time within 20 cycles, expected one");
    end
    lit("commit_ld", {7'd0, load_date}, {7'd0, m_state == 7}, 8'd1);
    lit("commit_hour", set_hour, to_bcd(m_hour), 8'h00);
    lit("commit_min", set_min, to_bcd(m_min), 8'h15);
    lit("commit_sec", set_sec, to_bcd(m_sec), 8'h58);
    lit("commit_day", set_day, to_bcd(m_day), 8'h28);
    tick();
    lit("post_load", {7'd0, load_time}, {7'd0, m_state == 7}, 8'd0);
    lit("post_fsel", {5'd0, field_sel}, m_fsel(), 8'd0);
    lit("post_blink", {7'd0, blink}, {7'd0, m_blink()}, 8'd0);
    btn_mode = 1'b0;
    repeat (10) tick();

    // Short bounces on inc must not count
    press(MODE, 8);
    for (int g = 0; g < 4; g++) begin
      btn_inc = 1'b1;
      repeat (3) tick();
      btn_inc = 1'b0;
      repeat (3) tick();
    end
    repeat (8) tick();
    lit("glitch_hour", set_hour, to_bcd(m_hour), 8'h23);
    lit("glitch_fsel", {5'd0, field_sel}, m_fsel(), 8'd1);
    press(MODE, 8);

    // Simultaneous mode+inc: only the mode action happens
    press(MODE | INC, 8);
    lit("dual_run_fsel", {5'd0, field_sel}, m_fsel(), 8'd1);
    lit("dual_run_hour", set_hour, to_bcd(m_hour), 8'h23);
    press(MODE | INC, 8);
    lit("dual_edit_fsel", {5'd0, field_sel}, m_fsel(), 8'd0);
    lit("dual_edit_hour", set_hour, to_bcd(m_hour), 8'h23);

    // Reset while editing the month
    press(MODE, 8);
    press_n(NEXT, 4);
    lit("pre_rst_fsel", {5'd0, field_sel}, m_fsel(), 8'd5);
    rst_n = 1'b0;
    model_reset();
    #1;
    lit("rst_edit_fsel", {5'd0, field_sel}, m_fsel(), 8'd0);
    lit("rst_edit_mon", set_mon, to_bcd(m_mon), 8'h01);
    lit("rst_edit_day", set_day, to_bcd(m_day), 8'h01);
    lit("rst_edit_load", {7'd0, load_time}, {7'd0, m_state == 7}, 8'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    lit("rst_blink", {7'd0, blink}, {7'd0, m_blink()}, 8'd0);
    lit("rst_fsel2", {5'd0, field_sel}, m_fsel(), 8'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
